// File: rtl/demux32_buf.sv
// demux32_buf: buffered 1-to-2 word demultiplexer.
//
// Each accepted input word goes to channel in_sel. Every channel has its own
// FIFO with a valid/ready handshake, so a stalled consumer on one channel never
// blocks words bound for the other.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   in_data/in_sel         word offered by the producer and its destination
//   in_valid/in_ready      producer handshake (in_ready is combinational)
//   outN_data/outN_valid   channel N head word (zero when empty) and non-empty flag
//   outN_ready             channel N consumer takes the head this cycle
//   count0/count1          registered channel occupancy, 0..DEPTH
//
// demux32_buf_fifo: one per-channel FIFO, instantiated once per channel.
//   push/wdata   write request (ignored when full)
//   pop          read request (ignored when empty)
//   rdata        head word, zero-gated when empty
//   valid/full   status flags derived from the occupancy count
//   count        registered occupancy

module demux32_buf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    cnt;
  logic             push_ok, pop_ok;

  assign full  = (cnt == CW'(DEPTH));
  assign valid = (cnt != '0);
  assign count = cnt;

  // Guard locally as well, so the FIFO never over/underflows on its own.
  assign push_ok = push && !full;
  assign pop_ok  = pop && valid;

  // Zero-gate the head so an empty channel presents a clean bus.
  assign rdata = valid ? mem[rptr] : '0;

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; a push in a reset cycle is still dropped so the
  // array never holds a word the pointers do not account for.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem[wptr] <= wdata;
  end
endmodule

module demux32_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out0_data,
  output logic                     out0_valid,
  input  logic                     out0_ready,
  output logic [WIDTH-1:0]         out1_data,
  output logic                     out1_valid,
  input  logic                     out1_ready,
  output logic [$clog2(DEPTH):0]   count0,
  output logic [$clog2(DEPTH):0]   count1
);
  localparam int NUM_CH = 2;
  localparam int CW     = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic             sel;
    logic [WIDTH-1:0] data;
  } req_t;

  req_t                          req;
  logic [NUM_CH-1:0]             ch_push, ch_pop, ch_valid, ch_full, ch_rdy;
  logic [NUM_CH-1:0][WIDTH-1:0]  ch_data;
  logic [NUM_CH-1:0][CW-1:0]     ch_count;

  assign req    = '{sel: in_sel, data: in_data};
  assign ch_rdy = {out1_ready, out0_ready};

  // No bypass: a full channel refuses input even if it pops this cycle.
  // Depends only on in_sel and the registered full flags.
  assign in_ready = !ch_full[req.sel];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_push[g] = in_valid && in_ready && (req.sel == 1'(g));
    assign ch_pop[g]  = ch_valid[g] && ch_rdy[g];

    demux32_buf_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (ch_push[g]),
      .wdata (req.data),
      .pop   (ch_pop[g]),
      .rdata (ch_data[g]),
      .valid (ch_valid[g]),
      .full  (ch_full[g]),
      .count (ch_count[g])
    );
  end

  assign out0_data  = ch_data[0];
  assign out0_valid = ch_valid[0];
  assign count0     = ch_count[0];
  assign out1_data  = ch_data[1];
  assign out1_valid = ch_valid[1];
  assign count1     = ch_count[1];
endmodule

// File: tb/tb_demux32_buf.sv
module tb_demux32_buf;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_sel, in_valid, in_ready;
  logic [31:0] out0_data, out1_data;
  logic        out0_valid, out0_ready, out1_valid, out1_ready;
  logic [1:0]  count0, count1;

  int n_chk  = 0;
  int n_fail = 0;

  demux32_buf #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .count0(count0), .count1(count1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic sel, input logic [31:0] d);
    in_sel = sel; in_data = d; in_valid = 1'b1; #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL push_ready sel=%0d: got %b want 1", sel, in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out0_ready = 1'b1; out1_ready = 1'b1;
    repeat (3) step();
    out0_ready = 1'b0; out1_ready = 1'b0;
    n_chk++;
    if (count0 !== 2'd0 || count1 !== 2'd0) begin
      n_fail++; $display("FAIL drain_empty: got %0d/%0d want 0/0", count0, count1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEADBEEF;
    out0_ready = 1'b0; out1_ready = 1'b0;
    repeat (2) step();
    n_chk++;
    if (count0 !== 2'd0 || count1 !== 2'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d/%0d want 0/0", count0, count1);
    end
    n_chk++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b/%b want 0/0", out0_valid, out1_valid);
    end
    n_chk++;
    if (out0_data !== 32'h0 || out1_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", out0_data, out1_data);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_sel0: got %b want 1", in_ready);
    end
    in_sel = 1'b1; #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_sel1: got %b want 1", in_ready);
    end
    in_valid = 1'b0; in_sel = 1'b0; rst_n = 1'b1;
    step();
    n_chk++;
    if (out0_valid !== 1'b0 || count0 !== 2'd0) begin
      n_fail++; $display("FAIL reset_no_word: valid %b count %0d want 0/0", out0_valid, count0);
    end
  endtask

  task automatic test_steering();
    push(1'b0, 32'h1);
    push(1'b1, 32'h2);
    push(1'b0, 32'h3);
    n_chk++;
    if (count0 !== 2'd2 || count1 !== 2'd1) begin
      n_fail++; $display("FAIL steer_count: got %0d/%0d want 2/1", count0, count1);
    end
    n_chk++;
    if (out0_data !== 32'h1 || out1_data !== 32'h2) begin
      n_fail++; $display("FAIL steer_data: got %h/%h want 1/2", out0_data, out1_data);
    end
    out0_ready = 1'b1; step(); out0_ready = 1'b0;
    n_chk++;
    if (out0_data !== 32'h3 || count0 !== 2'd1 || count1 !== 2'd1) begin
      n_fail++; $display("FAIL steer_pop: data %h cnt %0d/%0d want 3 1/1", out0_data, count0, count1);
    end
    drain();
  endtask

  task automatic test_full();
    push(1'b0, 32'hA);
    push(1'b0, 32'hB);
    in_sel = 1'b0; in_data = 32'hC; in_valid = 1'b1; #1;
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_ready_sel0: got %b want 0", in_ready);
    end
    step();
    n_chk++;
    if (count0 !== 2'd2 || in_ready !== 1'b0 || out0_data !== 32'hA) begin
      n_fail++; $display("FAIL full_hold: cnt %0d rdy %b data %h want 2 0 a", count0, in_ready, out0_data);
    end
    in_sel = 1'b1; #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_ready_sel1: got %b want 1", in_ready);
    end
    step(); in_valid = 1'b0;
    n_chk++;
    if (count1 !== 2'd1 || out1_data !== 32'hC || count0 !== 2'd2) begin
      n_fail++; $display("FAIL full_redirect: c1 %0d d1 %h c0 %0d want 1 c 2", count1, out1_data, count0);
    end
    // Full with consumer ready: no bypass in this cycle, slot free after the edge.
    in_sel = 1'b0; out0_ready = 1'b1; #1;
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_no_bypass: got %b want 0", in_ready);
    end
    step(); out0_ready = 1'b0; #1;
    n_chk++;
    if (in_ready !== 1'b1 || count0 !== 2'd1 || out0_data !== 32'hB) begin
      n_fail++; $display("FAIL full_refill: rdy %b cnt %0d data %h want 1 1 b", in_ready, count0, out0_data);
    end
    drain();
  endtask

  task automatic test_simul();
    push(1'b0, 32'h5);
    in_sel = 1'b0; in_data = 32'h6; in_valid = 1'b1; out0_ready = 1'b1; #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL simul_ready: got %b want 1", in_ready);
    end
    step(); in_valid = 1'b0; out0_ready = 1'b0;
    n_chk++;
    if (count0 !== 2'd1 || out0_data !== 32'h6) begin
      n_fail++; $display("FAIL simul_pushpop: cnt %0d data %h want 1 6", count0, out0_data);
    end
    drain();
  endtask

  task automatic test_wrap();
    int idx = 0, oidx = 0, cyc = 0;
    logic fin, fout;
    logic [31:0] od;
    while (oidx < 10 && cyc < 200) begin
      out1_ready = (cyc % 2 == 0);
      in_sel = 1'b1; in_valid = (idx < 10); in_data = 32'h10 + idx; #1;
      fin  = in_valid && in_ready;
      fout = out1_valid && out1_ready;
      od   = out1_data;
      step();
      if (fin) idx++;
      if (fout) begin
        n_chk++;
        if (od !== 32'h10 + oidx) begin
          n_fail++; $display("FAIL wrap_order[%0d]: got %h want %h", oidx, od, 32'h10 + oidx);
        end
        oidx++;
      end
      if (count1 > 2'd2) begin
        n_chk++; n_fail++; $display("FAIL wrap_count: got %0d want <=2", count1);
      end
      cyc++;
    end
    in_valid = 1'b0; out1_ready = 1'b0;
    n_chk++;
    if (oidx != 10 || count1 !== 2'd0) begin
      n_fail++; $display("FAIL wrap_done: got %0d words cnt %0d want 10 0", oidx, count1);
    end
  endtask

  task automatic test_midreset();
    push(1'b0, 32'h21); push(1'b0, 32'h22);
    push(1'b1, 32'h31); push(1'b1, 32'h32);
    n_chk++;
    if (count0 !== 2'd2 || count1 !== 2'd2) begin
      n_fail++; $display("FAIL midrst_fill: got %0d/%0d want 2/2", count0, count1);
    end
    rst_n = 1'b0; out0_ready = 1'b1; step(); rst_n = 1'b1; out0_ready = 1'b0;
    n_chk++;
    if (count0 !== 2'd0 || count1 !== 2'd0 || out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_clear: cnt %0d/%0d vld %b/%b want 0", count0, count1, out0_valid, out1_valid);
    end
    push(1'b0, 32'h77);
    n_chk++;
    if (out0_data !== 32'h77 || count0 !== 2'd1) begin
      n_fail++; $display("FAIL midrst_first: data %h cnt %0d want 77 1", out0_data, count0);
    end
    drain();
  endtask

  initial begin
    in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
    test_reset();
    test_steering();
    test_full();
    test_simul();
    test_wrap();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
